// File: rtl/sram_access_ctrl.sv
// Request/response front end for a single-port synchronous SRAM with a 3-entry read-return FIFO.
// Optional rd/wr performance counters are built only when SRAM_CTRL_PERF_EN is defined.
module sram_access_ctrl #(
  parameter int numWord     = 512,
  parameter int numBit      = 32,
  parameter int numWordAddr = $clog2(numWord)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   scan_en_in,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [numWordAddr-1:0] req_addr,
  input  logic [numBit-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [numBit-1:0]      rsp_rdata,
  output logic                   sram_ceb,
  output logic                   sram_web,
  output logic [numWordAddr-1:0] sram_a,
  output logic [numBit-1:0]      sram_d,
  input  logic [numBit-1:0]      sram_q,
  output logic [15:0]            rd_cnt,
  output logic [15:0]            wr_cnt
);

  logic [numBit-1:0] fifo_mem [3];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        count;
  logic              inflight;
  logic [2:0]        outstanding;
  logic              fire;
  logic              pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // An inflight read already owns a FIFO slot, so it counts against the space check.
  assign outstanding = {1'b0, count} + {2'b00, inflight};
  assign req_ready   = !RST && !scan_en_in && (outstanding < 3'd3);
  assign fire        = req_valid && req_ready;

  assign sram_ceb = !fire;
  assign sram_web = !(fire && req_we);
  assign sram_a   = req_addr;
  assign sram_d   = req_wdata;

  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 2'd0;
    end else begin
      inflight <= fire && !req_we;
      if (inflight) wr_ptr <= ptr_next(wr_ptr);
      if (pop)      rd_ptr <= ptr_next(rd_ptr);
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; rsp_rdata is gated by rsp_valid so stale
  // contents are never visible, and the data RAM stays a plain register file.
  always_ff @(posedge CLK) begin
    if (inflight) fifo_mem[wr_ptr] <= sram_q;
  end

`ifdef SRAM_CTRL_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else if (fire) begin
      if (req_we) begin
        if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end else begin
        if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`else
  assign rd_cnt = 16'd0;
  assign wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: behavioural SRAM, transaction-level model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sram_access_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          scan_en_in = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;

  sram_access_ctrl dut (
    .CLK(CLK), .RST(RST), .scan_en_in(scan_en_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural SRAM: one-cycle read latency.
  logic [DW-1:0] sram_mem  [512];
  logic [DW-1:0] model_mem [512];

  initial begin
    for (int i = 0; i < 512; i++) begin
      sram_mem[i]  = 32'hA500_0000 | i;
      model_mem[i] = 32'hA500_0000 | i;
    end
  end

  always @(posedge CLK) begin
    if (!sram_ceb) begin
      if (!sram_web) sram_mem[sram_a] <= sram_d;
      else           sram_q <= sram_mem[sram_a];
    end
  end

  // Transaction model: every accepted read is an outstanding entry until popped; it becomes
  // visible two cycles after its fire, and at most three may be outstanding.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } ent_t;

  ent_t        mq[$];
  ent_t        rsp_log[$];
  logic [15:0] exp_rd = '0;
  logic [15:0] exp_wr = '0;
  bit          seen_capture = 0;

  always @(negedge CLK) begin
    bit exp_ready, exp_valid, exp_fire;
    if (RST) begin
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, '0);
      check("rst_sram_ceb", sram_ceb, 1'b1);
      check("rst_rd_cnt", rd_cnt, '0);
      check("rst_wr_cnt", wr_cnt, '0);
      mq.delete();
      exp_rd = '0;
      exp_wr = '0;
      seen_capture = 0;
    end else begin
      exp_ready = !scan_en_in && (mq.size() < 3);
      exp_valid = (mq.size() > 0) && (mq[0].cyc + 2 <= cyc);
      exp_fire  = req_valid && exp_ready;
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rsp_rdata", rsp_rdata, mq[0].data);
        seen_capture = 1;
      end else if (!seen_capture) begin
        check("rsp_rdata_idle", rsp_rdata, '0);
      end
      check("sram_ceb", sram_ceb, !exp_fire);
      check("sram_web", sram_web, !(exp_fire && req_we));
      if (exp_fire) begin
        check("sram_a", sram_a, req_addr);
        if (req_we) check("sram_d", sram_d, req_wdata);
      end
`ifdef SRAM_CTRL_PERF_EN
      check("rd_cnt", rd_cnt, exp_rd);
      check("wr_cnt", wr_cnt, exp_wr);
`else
      check("rd_cnt", rd_cnt, 16'd0);
      check("wr_cnt", wr_cnt, 16'd0);
`endif
      if (exp_valid && rsp_ready) begin
        rsp_log.push_back('{rsp_rdata, cyc});
        void'(mq.pop_front());
      end
      if (exp_fire) begin
        if (req_we) begin
          model_mem[req_addr] = req_wdata;
          if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
        end else begin
          mq.push_back('{model_mem[req_addr], cyc});
          if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 16'd1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output int fc);
    bit done = 0;
    fc = -1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        done = 1;
        fc = cyc;
      end
    end
    check("issue_fired", done, 1'b1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    int fcs[8];
    int n0;
    int nfire;
    bit fired_now;
    int ceb_low;

    step(3);
    @(negedge CLK);
    check("lit_rst_ready", req_ready, 1'b0);
    check("lit_rst_ceb", sram_ceb, 1'b1);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("lit_post_rst_ready", req_ready, 1'b1);
    check("lit_post_rst_valid", rsp_valid, 1'b0);
    step(1);

    // Write then read back one word.
    rsp_ready = 1'b1;
    issue(1'b1, 9'h005, 32'hDEADBEEF, fc);
    n0 = rsp_log.size();
    issue(1'b0, 9'h005, '0, fc);
    step(6);
    check("wr_rd_count", rsp_log.size() - n0, 1);
    if (rsp_log.size() > n0) begin
      check("wr_rd_data", rsp_log[n0].data, 32'hDEADBEEF);
      check("wr_rd_latency", rsp_log[n0].cyc - fc, 2);
    end

    // Eight back-to-back reads with the consumer always ready.
    for (int i = 0; i < 8; i++) issue(1'b1, 9'(16 + i), 32'h1000_0000 + i, fc);
    n0 = rsp_log.size();
    for (int i = 0; i < 8; i++) issue(1'b0, 9'(16 + i), '0, fcs[i]);
    step(6);
    for (int i = 1; i < 8; i++) check("b2b_fire_cycle", fcs[i] - fcs[0], i);
    check("b2b_count", rsp_log.size() - n0, 8);
    if (rsp_log.size() >= n0 + 8) begin
      for (int i = 0; i < 8; i++) begin
        check("b2b_data", rsp_log[n0 + i].data, 32'h1000_0000 + i);
        check("b2b_rsp_cycle", rsp_log[n0 + i].cyc - rsp_log[n0].cyc, i);
      end
    end

    // Consumer stalled: only three reads fit, head data holds.
    for (int i = 0; i < 3; i++) issue(1'b1, 9'(32 + i), 32'h2000_0000 + i, fc);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 9'd32;
    nfire = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      fired_now = req_ready;
      if (fired_now) nfire++;
      if (rsp_valid) check("stall_hold_rdata", rsp_rdata, 32'h2000_0000);
      @(posedge CLK);
      #1;
      if (fired_now) req_addr = 9'(32 + nfire);
    end
    @(negedge CLK);
    check("stall_accepted", nfire, 3);
    check("stall_ready_low", req_ready, 1'b0);
    check("stall_valid", rsp_valid, 1'b1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    n0 = rsp_log.size();
    rsp_ready = 1'b1;
    step(5);
    check("stall_drain_count", rsp_log.size() - n0, 3);
    if (rsp_log.size() >= n0 + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("stall_drain_data", rsp_log[n0 + i].data, 32'h2000_0000 + i);
        check("stall_drain_cycle", rsp_log[n0 + i].cyc - rsp_log[n0].cyc, i);
      end
    end

    // Scan mode blocks every access.
    scan_en_in = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 9'd7;
    req_wdata  = 32'h5555_AAAA;
    ceb_low = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (!sram_ceb) ceb_low++;
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    scan_en_in = 1'b0;
    @(negedge CLK);
    check("scan_no_fire", ceb_low, 0);
    check("scan_mem_untouched", sram_mem[7], 32'hA500_0007);
`ifdef SRAM_CTRL_PERF_EN
    check("scan_wr_cnt", wr_cnt, 16'd12);
    check("scan_rd_cnt", rd_cnt, 16'd12);
`else
    check("scan_wr_cnt", wr_cnt, 16'd0);
    check("scan_rd_cnt", rd_cnt, 16'd0);
`endif
    step(1);

    // Scan rising right after a read fire still returns that read.
    n0 = rsp_log.size();
    issue(1'b0, 9'd16, '0, fc);
    scan_en_in = 1'b1;
    step(4);
    @(negedge CLK);
    check("scan_inflight_ready", req_ready, 1'b0);
    check("scan_inflight_count", rsp_log.size() - n0, 1);
    if (rsp_log.size() > n0) check("scan_inflight_data", rsp_log[n0].data, 32'h1000_0000);
    @(posedge CLK);
    #1;
    scan_en_in = 1'b0;

    // Reset in the cycle after a read fire discards that read.
    n0 = rsp_log.size();
    issue(1'b0, 9'd17, '0, fc);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(6);
    @(negedge CLK);
    check("rst_inflight_no_rsp", rsp_log.size() - n0, 0);
    check("rst_inflight_valid", rsp_valid, 1'b0);
    @(posedge CLK);
    #1;

    // Counter saturation.
    req_valid = 1'b1;
    req_we    = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      req_addr  = 9'(i);
      req_wdata = i;
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    @(negedge CLK);
`ifdef SRAM_CTRL_PERF_EN
    check("sat_wr_cnt", wr_cnt, 16'hFFFF);
`else
    check("sat_wr_cnt", wr_cnt, 16'd0);
`endif
    check("sat_rd_cnt", rd_cnt, 16'd0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter numWord, default 512, meaning SRAM depth in words.
REQ-002 SHALL have parameter numBit, default 32, meaning data width.
REQ-003 SHALL have parameter numWordAddr, default $clog2(numWord), meaning address width.
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port scan_en_in  input  1  scan mode; blocks all SRAM access.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request can be accepted.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  numWordAddr  word address.
REQ-011 SHALL have port req_wdata  input  numBit  write data.
REQ-012 SHALL have port rsp_valid  output  1  read data present.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes read data.
REQ-014 SHALL have port rsp_rdata  output  numBit  read data.
REQ-015 SHALL have port sram_ceb  output  1  SRAM chip enable, active-low.
REQ-016 SHALL have port sram_web  output  1  SRAM write enable, active-low.
REQ-017 SHALL have port sram_a  output  numWordAddr  SRAM address.
REQ-018 SHALL have port sram_d  output  numBit  SRAM write data.
REQ-019 SHALL have port sram_q  input  numBit  SRAM read data, valid the cycle after a read access.
REQ-020 SHALL have ports rd_cnt and wr_cnt  output  16 each  performance counters (see Configuration).

Function
REQ-021 SHALL accept a request in a cycle where req_valid and req_ready are both 1 (fire).
REQ-022 SHALL drive sram_ceb = !fire, sram_web = !req_we, sram_a = req_addr and sram_d = req_wdata combinationally in the fire cycle.
REQ-023 SHALL hold sram_ceb = 1 in every non-fire cycle, with sram_web = 1.
REQ-024 SHALL track a 1-bit inflight flag, set on read fire and cleared the next cycle.
REQ-025 SHALL capture sram_q into a 3-entry FIFO at the end of the cycle after a read fire.
REQ-026 SHALL drive req_ready = !scan_en_in && (occupancy + inflight) < 3, using registered state only.
REQ-027 SHALL produce no response for writes.
REQ-028 SHALL give a read fired in cycle N rsp_valid = 1 with its data no earlier than cycle N+2.
REQ-029 SHALL drive rsp_valid = FIFO non-empty and rsp_rdata = FIFO head, popping when rsp_valid && rsp_ready.
REQ-030 SHALL keep occupancy unchanged on a simultaneous capture and pop.
REQ-031 SHALL return responses in request order.
REQ-032 SHALL hold rsp_rdata stable while rsp_valid = 1 and rsp_ready = 0.
REQ-033 SHALL wrap FIFO read/write pointers modulo 3.
REQ-034 SHALL sustain one read per cycle when rsp_ready is held at 1.
REQ-035 SHALL, when scan_en_in rises, block new fires while still capturing an inflight read and still serving pops.

Reset
REQ-036 SHALL, on RST = 1 and regardless of CLK, clear inflight, FIFO pointers, occupancy and counters.
REQ-037 SHALL read 0 on rsp_valid and rsp_rdata during and after reset until the first capture.
REQ-038 SHALL drive sram_ceb = 1 and req_ready = 0 while RST = 1.
REQ-039 SHALL discard any read inflight at reset; it never produces a response.

Configuration
REQ-040 SHALL implement performance counting only when macro SRAM_CTRL_PERF_EN is defined.
REQ-041 SHALL, with SRAM_CTRL_PERF_EN defined, increment rd_cnt on each read fire and wr_cnt on each write fire, saturating at 16'hFFFF.
REQ-042 SHALL, without SRAM_CTRL_PERF_EN, keep ports rd_cnt and wr_cnt present, tie them to 0 and include no counter flops.

Verification
REQ-043 SHALL cover: write 32'hDEADBEEF to addr 9'h005 then read addr 9'h005 -> one response, rsp_rdata = 32'hDEADBEEF, 2 cycles after read fire.
REQ-044 SHALL cover: 8 back-to-back reads with rsp_ready = 1 -> req_ready never drops, 8 in-order responses on consecutive cycles.
REQ-045 SHALL cover: rsp_ready = 0 with reads issued -> exactly 3 reads accepted, req_ready = 0 afterwards, rsp_rdata stable; releasing rsp_ready drains 3 in order.
REQ-046 SHALL cover: scan_en_in = 1 with req_valid = 1 -> sram_ceb stays 1, no fire, counters unchanged.
REQ-047 SHALL cover: RST pulsed in the cycle after a read fire -> rsp_valid = 0 after reset, no stale response ever appears.
REQ-048 SHALL cover: with SRAM_CTRL_PERF_EN, 70000 writes -> wr_cnt = 16'hFFFF; without the macro -> wr_cnt = 0.
